serial_digit_adder: RTL and testbench
=====================================

// Module: serial_digit_adder
// PURPOSE
//  Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per cycle, LSB digit first.
//  Successor to the fixed 5-bit gate-level ripple adder; trades latency for area and adds valid/ready handshakes.
//  Sits between an operand source and a result consumer in the datapath; one operation in flight at a time.
// PARAMETERS
//  WIDTH  5  operand/result width in bits; must be an integer multiple of DIGIT
//  DIGIT  1  bits added per cycle; DIGIT==WIDTH gives a single-cycle RUN
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a/b/cin (and sub) valid
//  in_ready   out  1      block accepts operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  sub        in   1      subtract select (present only with SERIAL_ADD_SUB_EN)
//  out_valid  out  1      y/cout valid
//  out_ready  in   1      consumer accepts result
//  y          out  WIDTH  sum, (a+b+cin) mod 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, cout=0, carry reg=0, digit count=0.
//  - N = WIDTH/DIGIT. States IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0: capture a, b (inverted if sub), cin into the carry reg; count=0; go RUN.
//  - RUN: each cycle add digit[count] of a, b and the carry reg; write the DIGIT-bit sum into y[count*DIGIT +: DIGIT] and the carry into the carry reg; count++.
//    At the edge that writes digit N-1 (E0+N), go DONE. in_valid is ignored in RUN.
//  - DONE: out_valid=1; y and cout (= final carry) held stable until out_valid&&out_ready. At that edge go IDLE and drop out_valid.
//    in_ready rises one cycle later; no same-cycle result-pop/operand-accept.
//  - Latency: out_valid is high from edge E0+N; throughput is one operation per N+2 cycles minimum.
//  - y during RUN is partial and must not be sampled; it is valid only with out_valid.
//  - Reset mid-RUN/DONE aborts the operation immediately; the result is lost and no out_valid pulse occurs.
//  - cin=1 with all-ones operands: y=all-ones, cout=1; no overflow flag is produced.
// CONFIGURATION
//  - SERIAL_ADD_SUB_EN defined: sub port exists. sub is captured with the operands. sub=1 stores ~b, so y=a+~b+cin;
//    with cin=1 this is a-b and cout=1 means no borrow.
//  - Undefined: no sub port; the block always adds.
// STRUCTURE
//  - Package serial_digit_adder_pkg: state enum {IDLE,RUN,DONE}; function cnt_w(WIDTH,DIGIT)=$clog2(N) (min 1).
//  - Sub-module digit_add: combinational DIGIT-bit adder (a_d, b_d, ci -> s_d, co); instantiated once.
//  - Top: FSM, operand shift/index registers, carry reg, result register.
// TESTING (WIDTH=5, DIGIT=1 unless noted)
//  1. a=5'h13, b=5'h0E, cin=1, out_ready=1 -> out_valid 5 edges after accept; y=5'h02, cout=1.
//  2. a=5'h1F, b=5'h1F, cin=1 -> y=5'h1F, cout=1. a=0, b=0, cin=0 -> y=0, cout=0.
//  3. Backpressure: hold out_ready=0 for 3 cycles in DONE -> y/cout stable, in_ready=0; pulse out_ready -> IDLE, then in_ready=1.
//  4. Assert in_valid with new operands during RUN -> ignored; result matches the first operands only.
//  5. Assert rst on the 3rd RUN cycle -> all outputs are reset values at once; no out_valid; the next operation is correct.
//  6. DIGIT=5: out_valid 1 edge after accept. With SERIAL_ADD_SUB_EN: a=3, b=5, sub=1, cin=1 -> y=5'h1E, cout=0.

Source files
------------

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for the serial digit adder.
//   state_t : controller states IDLE -> RUN -> DONE -> IDLE
//   cnt_w   : width of the digit counter for a WIDTH/DIGIT split (at least 1)
package serial_digit_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width needed to index WIDTH/DIGIT digits; never narrower than 1 bit.
   function automatic int cnt_w(input int width, input int digit);
      int n;
      int w;
      n = width / digit;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/serial_digit_adder_digit_add.sv
// Combinational DIGIT-bit adder slice used once per cycle by the serial adder.
// Ports:
//   a_d, b_d : DIGIT-bit operand digits
//   ci       : carry into the digit
//   s_d      : DIGIT-bit digit sum
//   co       : carry out of the digit
module digit_add
   import serial_digit_adder_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             ci,
   output logic [DIGIT-1:0] s_d,
   output logic             co
);

   // Zero-extend by one bit so the top bit of the sum is the carry out.
   assign {co, s_d} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder: y = (a + b + cin) mod 2^WIDTH with carry out, computed
// DIGIT bits per cycle, least significant digit first, one operation in flight.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the `sub` port; when sub=1
// the stored B operand is inverted so that (with cin=1) y = a - b.
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, cin            : operands and carry-in
//   sub                  : subtract select (SERIAL_ADD_SUB_EN only)
//   out_valid / out_ready: result handshake
//   y, cout              : result and carry out, valid while out_valid is high
//   busy                 : high while an operation is in RUN or DONE
module serial_digit_adder
   import serial_digit_adder_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             busy
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = cnt_w(WIDTH, DIGIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               cout_q, cout_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [DIGIT-1:0]       sum_digit;
   logic                   carry_out;
   logic [WIDTH-1:0]       b_in;
   logic [WIDTH+DIGIT-1:0] y_cat;

`ifdef SERIAL_ADD_SUB_EN
   assign b_in = sub ? ~b : b;
`else
   assign b_in = b;
`endif

   // Operands are shifted right each RUN cycle, so the current digit is always the low DIGIT bits.
   digit_add #(.DIGIT(DIGIT)) u_digit_add (
      .a_d (opa_q[DIGIT-1:0]),
      .b_d (opb_q[DIGIT-1:0]),
      .ci  (carry_q),
      .s_d (sum_digit),
      .co  (carry_out)
   );

   // The result is filled from the top and shifted down; after N digits digit k sits at y[k*DIGIT +: DIGIT].
   assign y_cat = {sum_digit, y_q};

   // Next-state and datapath update for the IDLE/RUN/DONE controller.
   always_comb begin
      state_d     = state_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      y_d         = y_q;
      cout_d      = cout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               opa_d      = a;
               opb_d      = b_in;
               carry_d    = cin;
               cnt_d      = {CNT_W{1'b0}};
               state_d    = RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            opa_d   = opa_q >> DIGIT;
            opb_d   = opb_q >> DIGIT;
            carry_d = carry_out;
            y_d     = y_cat[WIDTH+DIGIT-1:DIGIT];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               cout_d      = carry_out;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            // in_ready rises at the pop edge, so a pop and an accept never share a cycle.
            if (out_valid_q && out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         opa_q       <= {WIDTH{1'b0}};
         opb_q       <= {WIDTH{1'b0}};
         carry_q     <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         y_q         <= {WIDTH{1'b0}};
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         y_q         <= y_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign cout      = cout_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder: a WIDTH=5/DIGIT=1 instance (dut1)
// and a WIDTH=5/DIGIT=5 instance (dut5) share clock, reset and operands.
module tb_serial_digit_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] a = 5'd0;
   logic [4:0] b = 5'd0;
   logic       cin = 1'b0;
   logic       sub = 1'b0;

   logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic       in_ready1, out_valid1, cout1, busy1;
   logic [4:0] y1;

   logic       in_valid5 = 1'b0, out_ready5 = 1'b0;
   logic       in_ready5, out_valid5, cout5, busy5;
   logic [4:0] y5;

   int errors = 0;
   int checks = 0;
   int lat;

   always #5 clk = ~clk;

   serial_digit_adder #(.WIDTH(5), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid1), .out_ready(out_ready1),
      .y(y1), .cout(cout1), .busy(busy1)
   );

   serial_digit_adder #(.WIDTH(5), .DIGIT(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
      .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid5), .out_ready(out_ready5),
      .y(y5), .cout(cout5), .busy(busy5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands for one cycle on the chosen instance; returns at the negedge after accept edge E0.
   task automatic start_op(input int which, input logic [4:0] av, input logic [4:0] bv,
                           input logic cv, input logic sv);
      a   = av;
      b   = bv;
      cin = cv;
      sub = sv;
      if (which == 5) begin
         chk("in_ready5_before_accept", {31'd0, in_ready5}, 32'd1);
         in_valid5 = 1'b1;
      end else begin
         chk("in_ready1_before_accept", {31'd0, in_ready1}, 32'd1);
         in_valid1 = 1'b1;
      end
      @(negedge clk);
      in_valid1 = 1'b0;
      in_valid5 = 1'b0;
   endtask

   // Count edges after E0 until out_valid, bounded so a dead DUT still reaches the summary.
   task automatic wait_done(input int which, input int exp_lat, input string tag);
      lat = 0;
      while ((((which == 5) ? out_valid5 : out_valid1) == 1'b0) && (lat < 20)) begin
         @(negedge clk);
         lat++;
      end
      chk(tag, lat, exp_lat);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready",  {31'd0, in_ready1},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
      chk("rst_busy",      {31'd0, busy1},      32'd0);
      chk("rst_y",         {27'd0, y1},         32'd0);
      chk("rst_cout",      {31'd0, cout1},      32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1. 0x13 + 0x0E + 1 = 0x22 -> y=0x02, cout=1, latency 5
      out_ready1 = 1'b1;
      start_op(1, 5'h13, 5'h0E, 1'b1, 1'b0);
      chk("t1_busy_run", {31'd0, busy1}, 32'd1);
      chk("t1_in_ready_run", {31'd0, in_ready1}, 32'd0);
      wait_done(1, 5, "t1_latency");
      chk("t1_y",    {27'd0, y1},    32'h02);
      chk("t1_cout", {31'd0, cout1}, 32'd1);
      @(negedge clk);
      chk("t1_popped", {31'd0, out_valid1}, 32'd0);

      // 2. all ones with carry-in, then all zeros
      start_op(1, 5'h1F, 5'h1F, 1'b1, 1'b0);
      wait_done(1, 5, "t2a_latency");
      chk("t2a_y",    {27'd0, y1},    32'h1F);
      chk("t2a_cout", {31'd0, cout1}, 32'd1);
      @(negedge clk);
      start_op(1, 5'h00, 5'h00, 1'b0, 1'b0);
      wait_done(1, 5, "t2b_latency");
      chk("t2b_y",    {27'd0, y1},    32'h00);
      chk("t2b_cout", {31'd0, cout1}, 32'd0);
      @(negedge clk);

      // 3. Backpressure in DONE: 0x0F + 0x01 + 0 = 0x10
      out_ready1 = 1'b0;
      start_op(1, 5'h0F, 5'h01, 1'b0, 1'b0);
      wait_done(1, 5, "t3_latency");
      for (int i = 0; i < 3; i++) begin
         chk("t3_hold_y",        {27'd0, y1},         32'h10);
         chk("t3_hold_cout",     {31'd0, cout1},      32'd0);
         chk("t3_hold_valid",    {31'd0, out_valid1}, 32'd1);
         chk("t3_hold_in_ready", {31'd0, in_ready1},  32'd0);
         @(negedge clk);
      end
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      chk("t3_pop_valid",    {31'd0, out_valid1}, 32'd0);
      chk("t3_pop_in_ready", {31'd0, in_ready1},  32'd1);
      chk("t3_pop_busy",     {31'd0, busy1},      32'd0);

      // 4. in_valid during RUN ignored: 0x0A + 0x07 = 0x11
      out_ready1 = 1'b1;
      start_op(1, 5'h0A, 5'h07, 1'b0, 1'b0);
      a = 5'h1F;
      b = 5'h1F;
      cin = 1'b1;
      in_valid1 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 2;
      while (out_valid1 == 1'b0 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("t4_latency", lat, 5);
      chk("t4_y",    {27'd0, y1},    32'h11);
      chk("t4_cout", {31'd0, cout1}, 32'd0);
      @(negedge clk);
      chk("t4_no_second_op", {31'd0, busy1}, 32'd0);

      // 5. Reset during the 3rd RUN cycle aborts the operation
      start_op(1, 5'h1F, 5'h1F, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_rst_out_valid", {31'd0, out_valid1}, 32'd0);
      chk("t5_rst_in_ready",  {31'd0, in_ready1},  32'd1);
      chk("t5_rst_busy",      {31'd0, busy1},      32'd0);
      chk("t5_rst_y",         {27'd0, y1},         32'd0);
      chk("t5_rst_cout",      {31'd0, cout1},      32'd0);
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid1) lat++;
      end
      chk("t5_no_out_valid", lat, 0);
      start_op(1, 5'h15, 5'h0B, 1'b0, 1'b0);
      wait_done(1, 5, "t5_next_latency");
      chk("t5_next_y",    {27'd0, y1},    32'h00);
      chk("t5_next_cout", {31'd0, cout1}, 32'd1);
      @(negedge clk);
      out_ready1 = 1'b0;

      // 6. DIGIT=5 instance: single RUN cycle
      out_ready5 = 1'b1;
      start_op(5, 5'h13, 5'h0E, 1'b1, 1'b0);
      wait_done(5, 1, "t6_latency");
      chk("t6_y",    {27'd0, y5},    32'h02);
      chk("t6_cout", {31'd0, cout5}, 32'd1);
      @(negedge clk);
`ifdef SERIAL_ADD_SUB_EN
      // 3 - 5: 3 + ~5 + 1 = 0x1E, borrow -> cout=0
      start_op(5, 5'h03, 5'h05, 1'b1, 1'b1);
      wait_done(5, 1, "t6_sub_latency");
      chk("t6_sub_y",    {27'd0, y5},    32'h1E);
      chk("t6_sub_cout", {31'd0, cout5}, 32'd0);
      @(negedge clk);
      sub = 1'b0;
`endif
      chk("t6_idle_in_ready", {31'd0, in_ready5}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
